// File: rtl/pe_elastic_reg.sv
// pe_elastic_reg: valid/ready handshaked register stage with DEPTH entries of WIDTH bits.
// It absorbs back-pressure between PE pipeline stages without dropping words.
// It provides a synchronous flush and an occupancy count.
// The head entry is held in a dedicated output register, so there is no fall-through.
// in_ready depends only on registered occupancy.
module pe_elastic_reg #(
  parameter int                 WIDTH       = 32,
  parameter int                 DEPTH       = 2,
  parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}},
  localparam int                CW          = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  localparam int             PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0]  ONE_COUNT  = CW'(1);
  localparam logic [PW-1:0]  LAST_PTR   = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    rd_ptr_next;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             push;
  logic             pop;

  // Pointers wrap at DEPTH-1, so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign in_ready    = (count_q != FULL_COUNT);
  assign out_valid   = (count_q != '0);
  assign out_data    = out_data_q;
  assign count       = count_q;
  assign push        = in_valid & in_ready;
  assign pop         = out_valid & out_ready;
  assign rd_ptr_next = ptr_inc(rd_ptr_q);

  // Next-state for occupancy, pointers and the registered head; flush discards everything.
  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    out_data_d = out_data_q;
    if (flush) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      out_data_d = RESET_VALUE;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_next;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + ONE_COUNT;
        2'b01:   count_d = count_q - ONE_COUNT;
        default: count_d = count_q;
      endcase
      if (pop && (count_q > ONE_COUNT)) begin
        out_data_d = mem_q[rd_ptr_next];
      end else if (push && ((count_q == '0) || (pop && (count_q == ONE_COUNT)))) begin
        out_data_d = in_data;
      end
    end
  end

  // Storage write: every accepted word lands at the write pointer; a flushed push is dropped.
  always_comb begin
    mem_d = mem_q;
    if (push && !flush) begin
      mem_d[wr_ptr_q] = in_data;
    end
  end

  // Storage array carries no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  // Control registers with synchronous active-high reset taking priority over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      out_data_q <= RESET_VALUE;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      out_data_q <= out_data_d;
    end
  end

endmodule
